// File: rtl/ipm_gf_pkg.sv
// Shared GF(2^8) constants, byte type and FSM state encoding for the serial
// IPM unmasking block.
package ipm_gf_pkg;

    localparam int BYTE_W = 8;

    // Low byte of x^8+x^4+x^3+x+1; the x^8 term is implied by the carry-out.
    localparam logic [BYTE_W-1:0] GF_POLY = 8'h1B;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier: shift-and-add over the bits of b,
// reducing a by the field polynomial on every doubling.
module gf256_mul
    import ipm_gf_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    output logic [BYTE_W-1:0] p
);

    byte_t aa;
    byte_t bb;
    byte_t acc;

    always_comb begin
        aa  = a;
        bb  = b;
        acc = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            if (bb[0]) begin
                acc = acc ^ aa;
            end
            bb = bb >> 1;
            aa = aa[BYTE_W-1] ? ((aa << 1) ^ GF_POLY) : (aa << 1);
        end
        p = acc;
    end

endmodule

// File: rtl/ip_unmask_serial.sv
// Serial IPM unmasking: S = XOR_i L[i]*R[i] over V shares, computed LANES
// products per beat across V/LANES beats, with valid/ready on both sides.
//
// state | meaning
// IDLE  | ready for operands; output idle
// ACC   | one beat of LANES products folded into acc per cycle
// DONE  | out_s valid, held until out_ready
module ip_unmask_serial
    import ipm_gf_pkg::*;
#(
    parameter int V     = 8,
    parameter int LANES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [V*BYTE_W-1:0]   in_l,
    input  logic [V*BYTE_W-1:0]   in_r,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BYTE_W-1:0]     out_s,
    output logic                  busy
);

    localparam int N  = V / LANES;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    if ((LANES < 1) || (LANES > V) || ((V % LANES) != 0)) begin : g_bad_cfg
        $error("ip_unmask_serial: LANES must divide V with 1 <= LANES <= V");
    end

    state_t              state_q;
    state_t              state_d;
    logic [KW-1:0]       k_q;
    logic [V*BYTE_W-1:0] l_q;
    logic [V*BYTE_W-1:0] r_q;
    byte_t               acc_q;
    byte_t               out_s_q;

    logic [V*BYTE_W-1:0] l_sel;
    logic [V*BYTE_W-1:0] r_sel;
    byte_t               prod  [LANES];
    byte_t               chain [LANES+1];
    byte_t               beat_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)        state_d = ACC;
            ACC:     if (k_q == K_LAST)   state_d = DONE;
            DONE:    if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_s     = out_s_q;

    // Beat mux: bring shares k*LANES .. k*LANES+LANES-1 down to the low lanes.
    assign l_sel = l_q >> (int'(k_q) * LANES * BYTE_W);
    assign r_sel = r_q >> (int'(k_q) * LANES * BYTE_W);

    assign chain[0] = '0;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        gf256_mul u_mul (
            .a (l_sel[j*BYTE_W +: BYTE_W]),
            .b (r_sel[j*BYTE_W +: BYTE_W]),
            .p (prod[j])
        );
        assign chain[j+1] = chain[j] ^ prod[j];
    end

    assign beat_x = chain[LANES];

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q     <= '0;
            l_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            out_s_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        l_q   <= in_l;
                        r_q   <= in_r;
                        acc_q <= '0;
                        k_q   <= '0;
                    end
                end
                ACC: begin
                    acc_q <= acc_q ^ beat_x;
                    // The last beat's products go straight to out_s so it is valid on entry to DONE.
                    if (k_q == K_LAST) begin
                        out_s_q <= acc_q ^ beat_x;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_unmask_serial.sv
// Directed and randomised checks of ip_unmask_serial in the V=8/LANES=2 and
// V=8/LANES=8 configurations against hand-computed values and a field model.
module tb_ip_unmask_serial;

    localparam int V  = 8;
    localparam int W  = V * 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;

    logic         a_in_valid;
    logic         a_in_ready;
    logic [W-1:0] a_in_l;
    logic [W-1:0] a_in_r;
    logic         a_out_valid;
    logic         a_out_ready;
    logic [7:0]   a_out_s;
    logic         a_busy;

    logic         b_in_valid;
    logic         b_in_ready;
    logic [W-1:0] b_in_l;
    logic [W-1:0] b_in_r;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [7:0]   b_out_s;
    logic         b_busy;

    int n_pass = 0;
    int n_tot  = 0;

    ip_unmask_serial #(.V(V), .LANES(2)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_l      (a_in_l),
        .in_r      (a_in_r),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_s     (a_out_s),
        .busy      (a_busy)
    );

    ip_unmask_serial #(.V(V), .LANES(8)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_l      (b_in_l),
        .in_r      (b_in_r),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_s     (b_out_s),
        .busy      (b_busy)
    );

    // Reference: carry-less product to 15 bits, then long division by 0x11B.
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ (15'(x) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_ip(input logic [W-1:0] l, input logic [W-1:0] r);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < V; i++) begin
            s = s ^ ref_mul(l[8*i +: 8], r[8*i +: 8]);
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn_a(input logic [W-1:0] l, input logic [W-1:0] r,
                         input logic [7:0] exp_s, input string name);
        int cnt;
        a_in_l     = l;
        a_in_r     = r;
        a_in_valid = 1'b1;
        n_tot++;
        if (a_in_ready !== 1'b1) $display("FAIL %s in_ready before accept got %b want 1", name, a_in_ready);
        else n_pass++;
        step();
        a_in_valid = 1'b0;
        a_in_l     = ~l;
        a_in_r     = r ^ 64'hA5A5_5A5A_C3C3_3C3C;
        cnt = 0;
        while (a_out_valid !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        n_tot++;
        if (cnt != 4) $display("FAIL %s latency got %0d want 4", name, cnt);
        else n_pass++;
        n_tot++;
        if (a_out_s !== exp_s) $display("FAIL %s out_s got %h want %h", name, a_out_s, exp_s);
        else n_pass++;
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        n_tot++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0)
            $display("FAIL %s return to idle got in_ready=%b out_valid=%b want 1/0", name, a_in_ready, a_out_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_tot++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_out_s !== 8'h00)
            $display("FAIL reset_a got ov=%b ir=%b busy=%b s=%h want 0/1/0/00", a_out_valid, a_in_ready, a_busy, a_out_s);
        else n_pass++;
        n_tot++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_busy !== 1'b0 || b_out_s !== 8'h00)
            $display("FAIL reset_b got ov=%b ir=%b busy=%b s=%h want 0/1/0/00", b_out_valid, b_in_ready, b_busy, b_out_s);
        else n_pass++;
    endtask

    task automatic test_single_lane();
        txn_a(64'h0000_0000_0000_0057, 64'h0000_0000_0000_0083, 8'hC1, "lane0");
    endtask

    task automatic test_last_lane();
        txn_a(64'h5700_0000_0000_0057, 64'h1300_0000_0000_0083, 8'h3F, "lane0_lane7");
    endtask

    task automatic test_cancel();
        txn_a(64'h0000_0001_5300_0000, 64'h0000_0001_CA00_0000, 8'h00, "inverse_pair");
        txn_a(64'h0101_0101_0101_0101, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, "even_repeat");
        txn_a(64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0000, 8'h00, "zero_r");
    endtask

    task automatic test_backpressure();
        int cnt;
        a_in_l     = 64'h0000_0000_0000_0057;
        a_in_r     = 64'h0000_0000_0000_0083;
        a_in_valid = 1'b1;
        step();
        a_in_l = 64'h5700_0000_0000_0057;
        a_in_r = 64'h1300_0000_0000_0083;
        cnt = 0;
        while (a_out_valid !== 1'b1 && cnt < 20) begin
            n_tot++;
            if (a_in_ready !== 1'b0) $display("FAIL bp_busy in_ready got %b want 0", a_in_ready);
            else n_pass++;
            step();
            cnt++;
        end
        n_tot++;
        if (cnt != 4) $display("FAIL bp latency got %0d want 4", cnt);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tot++;
            if (a_out_valid !== 1'b1 || a_out_s !== 8'hC1 || a_in_ready !== 1'b0)
                $display("FAIL bp_hold cycle %0d got ov=%b s=%h ir=%b want 1/c1/0", i, a_out_valid, a_out_s, a_in_ready);
            else n_pass++;
        end
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        n_tot++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_s !== 8'hC1)
            $display("FAIL bp_release got ir=%b ov=%b s=%h want 1/0/c1", a_in_ready, a_out_valid, a_out_s);
        else n_pass++;
        step();
        a_in_valid = 1'b0;
        n_tot++;
        if (a_busy !== 1'b1 || a_in_ready !== 1'b0)
            $display("FAIL bp_next_accept got busy=%b ir=%b want 1/0", a_busy, a_in_ready);
        else n_pass++;
        cnt = 0;
        while (a_out_valid !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        n_tot++;
        if (cnt != 4 || a_out_s !== 8'h3F)
            $display("FAIL bp_next_result got lat=%0d s=%h want 4/3f", cnt, a_out_s);
        else n_pass++;
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_in_l     = 64'h5700_0000_0000_0057;
        a_in_r     = 64'h1300_0000_0000_0083;
        a_in_valid = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_in_valid = 1'b0;
        n_tot++;
        if (a_out_valid !== 1'b0 || a_out_s !== 8'h00 || a_in_ready !== 1'b1 || a_busy !== 1'b0)
            $display("FAIL reset_mid got ov=%b s=%h ir=%b busy=%b want 0/00/1/0", a_out_valid, a_out_s, a_in_ready, a_busy);
        else n_pass++;
        txn_a(64'h0000_0000_0000_0057, 64'h0000_0000_0000_0083, 8'hC1, "after_reset");
    endtask

    task automatic test_full_parallel();
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic [7:0]   exp_s;
        int           cnt;
        int           bad_lat;
        int           bad_s;
        bad_lat = 0;
        bad_s   = 0;
        for (int t = 0; t < 1000; t++) begin
            l = {$urandom(), $urandom()};
            r = {$urandom(), $urandom()};
            exp_s = ref_ip(l, r);
            b_in_l     = l;
            b_in_r     = r;
            b_in_valid = 1'b1;
            step();
            b_in_valid = 1'b0;
            b_in_l     = ~l;
            cnt = 0;
            while (b_out_valid !== 1'b1 && cnt < 10) begin
                step();
                cnt++;
            end
            n_tot++;
            if (cnt != 1) begin
                if (bad_lat < 5) $display("FAIL par_latency txn %0d got %0d want 1", t, cnt);
                bad_lat++;
            end else n_pass++;
            n_tot++;
            if (b_out_s !== exp_s) begin
                if (bad_s < 5) $display("FAIL par_out_s txn %0d got %h want %h", t, b_out_s, exp_s);
                bad_s++;
            end else n_pass++;
            b_out_ready = 1'b1;
            step();
            b_out_ready = 1'b0;
        end
    endtask

    initial begin
        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_in_l      = '0;
        a_in_r      = '0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_l      = '0;
        b_in_r      = '0;
        b_out_ready = 1'b0;
        test_reset();
        test_single_lane();
        test_last_lane();
        test_cancel();
        test_backpressure();
        test_reset_mid();
        test_full_parallel();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/ip_unmask_serial.md
Name: ip_unmask_serial

Overview:
- Sequential successor of the combinational IPM unmasking block.
- Recovers one unmasked byte as the GF(2^8) inner product S = XOR over i of L[i]·R[i], for V shares.
- Uses LANES multipliers per cycle, time-multiplexed over V/LANES cycles, with valid/ready handshakes on input and output.
- Sits between the masked datapath output and any consumer that needs plain bytes; trades latency for area.

Parameters:
V, 8, number of shares per operand (bytes in L and R); V ≥ 1.
LANES, 2, GF(2^8) multipliers instantiated; must divide V, 1 ≤ LANES ≤ V; checked by elaboration-time assertion.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  L/R operands valid
in_ready  output  1  block can accept operands
in_l  input  V*8  public vector L; share i at bits [8i+7:8i]
in_r  input  V*8  masked vector R; same lane ordering as in_l
out_valid  output  1  out_s holds a result
out_ready  input  1  consumer accepts result
out_s  output  8  unmasked byte S
busy  output  1  high in ACC or DONE

Behaviour:
- Field: GF(2^8), reduction polynomial x^8+x^4+x^3+x+1 (0x11B). Addition is XOR. Multiplication is fully combinational within one cycle.
- N = V/LANES accumulation cycles per transaction.
- FSM states:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On in_valid&&in_ready: register in_l and in_r, clear acc to 0, set beat counter k=0, go to ACC.
  - ACC:
    - Each cycle: acc ← acc XOR (XOR over j<LANES of L[k*LANES+j]·R[k*LANES+j]); k ← k+1.
    - On the cycle with k=N-1: out_s ← final accumulated value (acc XOR that beat's products), go to DONE.
  - DONE:
    - out_valid=1; out_s stable.
    - On out_ready: go to IDLE. out_s keeps its last value; it is not cleared.
- Latency:
  - Acceptance edge at t0 → out_valid high after N further rising edges.
  - With LANES=V, out_valid is high one cycle after acceptance.
- Throughput: one transaction per N+2 cycles with out_ready held high. in_ready is low in ACC and DONE; no input-side pipelining.
- Captured operands are held internally. in_l and in_r may change freely after the acceptance edge without affecting the result.
- in_valid asserted in ACC or DONE is ignored. The upstream must hold it until in_ready.
- out_valid, once high, stays high and out_s stays stable until out_ready is sampled high (AXI-style no-retract).
- k counter width: clog2(N), minimum 1 bit. No wrap beyond N-1 occurs because the state leaves ACC at N-1.
- Zero operands: L or R all-zero → S=0x00.
- Reset:
  - Values: state=IDLE, acc=0, out_s=0x00, out_valid=0, in_ready=1, busy=0, k=0.
  - Reset mid-ACC or mid-DONE abandons the transaction with no output.
  - Reset has priority over any simultaneous handshake.
- No X propagation: operand registers reset to 0.

Decomposition:
- Package ipm_gf_pkg:
  - GF_POLY = 8'h1B (reduction tail)
  - BYTE_W = 8
  - byte_t typedef
  - FSM state enum {IDLE, ACC, DONE}
- Sub-module gf256_mul: combinational 8x8 GF(2^8) multiplier using ipm_gf_pkg::GF_POLY. Instantiated LANES times via generate.
- Top level contains FSM, operand registers, beat mux, XOR tree and accumulator.

Test Plan:
- V=8, LANES=2, L lane0=0x57, R lane0=0x83, other lanes 0 → out_s=0xC1, out_valid exactly 4 edges after acceptance.
- Lane0 0x57·0x83 plus lane7 L=0x57, R=0x13, others 0 → out_s=0xC1^0xFE=0x3F. Exercises the last beat and lane7 indexing.
- L lane3=0x53, R lane3=0xCA (inverse pair), plus L lane4=0x01, R lane4=0x01 → out_s=0x00. Also L=all 0x01, R=all 0xAA (even V) → 0x00.
- Backpressure: out_ready low 5 cycles after out_valid → out_s and out_valid stable; in_ready=0 while in_valid held high; after out_ready pulse, in_ready=1 on the next cycle and the next transaction is accepted.
- Reset asserted in the 2nd ACC cycle → next cycle out_valid=0, out_s=0x00, in_ready=1, busy=0; the new transaction then yields the correct result.
- LANES=V=8 configuration, random L/R for 1000 transactions vs. reference model → all match, latency 1.
